// File: rtl/mem_port_arbiter_if.sv
// Request, response and RAM-side signals of the IF/MEM shared-RAM arbiter.
// The slave modport is the arbiter; the master modport is the requesters plus the RAM.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_stall;
  logic              if_valid;
  logic [DATA_W-1:0] if_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_stall;
  logic              mem_valid;
  logic [DATA_W-1:0] mem_rdata;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_stall, if_valid, if_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_stall, mem_valid, mem_rdata,
    output ram_addr, ram_we, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_stall, if_valid, if_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_stall, mem_valid, mem_rdata,
    input  ram_addr, ram_we, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between fetch (IF) and memory stage (MEM); MEM has priority,
// with a starvation counter that forces an IF win after STARVE_MAX consecutive IF losses.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 7,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  mem_port_arbiter_if.slave    bus
);

  localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    RET_NONE,
    RET_IF,
    RET_MEM
  } ret_t;

  ret_t             owner;
  logic             owner_wr;
  logic [CNT_W-1:0] starve_cnt;
  logic             starved;
  logic             grant_if;
  logic             grant_mem;

  assign starved = (starve_cnt == CNT_W'(STARVE_MAX));

  always_comb begin
    grant_if  = bus.if_req & (~bus.mem_req | starved);
    grant_mem = bus.mem_req & ~grant_if;

    bus.if_stall  = bus.if_req & ~grant_if;
    bus.mem_stall = bus.mem_req & ~grant_mem;

    bus.ram_addr  = '0;
    bus.ram_we    = 1'b0;
    bus.ram_wdata = '0;
    if (grant_mem) begin
      bus.ram_addr  = bus.mem_addr;
      bus.ram_we    = bus.mem_we;
      bus.ram_wdata = bus.mem_wdata;
    end else if (grant_if) begin
      bus.ram_addr  = bus.if_addr;
    end
  end

  // Owner of the in-flight access; its return overlaps the next cycle's issue.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      owner      <= RET_NONE;
      owner_wr   <= 1'b0;
      starve_cnt <= '0;
    end else begin
      if (grant_mem)     owner <= RET_MEM;
      else if (grant_if) owner <= RET_IF;
      else               owner <= RET_NONE;
      owner_wr <= grant_mem & bus.mem_we;

      if (grant_if || !bus.if_req) starve_cnt <= '0;
      else if (!starved)           starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    bus.if_valid  = (owner == RET_IF);
    bus.if_rdata  = '0;
    bus.mem_valid = (owner == RET_MEM);
    bus.mem_rdata = '0;
    if (owner == RET_IF) bus.if_rdata = bus.ram_rdata;
    if ((owner == RET_MEM) && !owner_wr) bus.mem_rdata = bus.ram_rdata;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by random traffic, checked
// against a cycle-level reference model with its own shadow memory.
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W     = 7;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned STARVE_MAX = 3;
  localparam int unsigned DEPTH      = 1 << ADDR_W;

  logic clock;
  logic reset;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors;
  int checks;

  logic [DATA_W-1:0] ram    [DEPTH];
  logic [DATA_W-1:0] shadow [DEPTH];

  // Reference model state: consecutive IF losses, and the expected return for the next cycle.
  int unsigned       losses;
  int                ret_kind;   // 0 none, 1 IF read, 2 MEM read, 3 MEM write
  logic [DATA_W-1:0] ret_data;
  bit                m_if_stall;
  bit                m_mem_stall;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rst, input bit ir, input logic [ADDR_W-1:0] ia,
                      input bit mr, input bit mw, input logic [ADDR_W-1:0] ma,
                      input logic [DATA_W-1:0] md);
    bit                gi, gm;
    logic [ADDR_W-1:0] a_addr;
    logic              a_we;
    logic [DATA_W-1:0] a_wd;
    @(negedge clock);
    reset         = rst;
    bus.if_req    = ir;
    bus.if_addr   = ia;
    bus.mem_req   = mr;
    bus.mem_we    = mw;
    bus.mem_addr  = ma;
    bus.mem_wdata = md;
    #1;
    if (!rst) begin
      ret_kind = 0;
      losses   = 0;
    end
    gi = ir && (!mr || losses >= STARVE_MAX);
    gm = mr && !gi;
    m_if_stall  = ir && !gi;
    m_mem_stall = mr && !gm;

    chk("if_stall",  bus.if_stall,  m_if_stall);
    chk("mem_stall", bus.mem_stall, m_mem_stall);
    chk("ram_we",    bus.ram_we,    gm && mw);
    chk("ram_addr",  bus.ram_addr,  gm ? ma : (gi ? ia : '0));
    if (!gi) chk("ram_wdata", bus.ram_wdata, gm ? md : '0);
    chk("if_valid",  bus.if_valid,  ret_kind == 1);
    chk("if_rdata",  bus.if_rdata,  (ret_kind == 1) ? ret_data : '0);
    chk("mem_valid", bus.mem_valid, ret_kind >= 2);
    chk("mem_rdata", bus.mem_rdata, (ret_kind == 2) ? ret_data : '0);

    if (!rst) begin
      ret_kind = 0;
      ret_data = '0;
    end else if (gi) begin
      ret_kind = 1;
      ret_data = shadow[ia];
    end else if (gm) begin
      ret_kind = mw ? 3 : 2;
      ret_data = mw ? '0 : shadow[ma];
      if (mw) shadow[ma] = md;
    end else begin
      ret_kind = 0;
      ret_data = '0;
    end
    if (!rst || gi || !ir) losses = 0;
    else if (losses < STARVE_MAX) losses++;

    a_addr = bus.ram_addr;
    a_we   = bus.ram_we;
    a_wd   = bus.ram_wdata;
    @(posedge clock);
    bus.ram_rdata = ram[a_addr];
    if (a_we) ram[a_addr] = a_wd;
  endtask

  logic [ADDR_W-1:0] c_ia, c_ma;
  logic [DATA_W-1:0] c_md;
  bit                c_ir, c_mr, c_mw, c_rst;

  initial begin
    errors = 0;
    checks = 0;
    losses = 0;
    ret_kind = 0;
    ret_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      logic [DATA_W-1:0] v;
      v = $urandom;
      ram[i]    = v;
      shadow[i] = v;
    end
    ram[5]    = 32'hDEADBEEF;
    shadow[5] = 32'hDEADBEEF;
    bus.ram_rdata = '0;

    // Scenario 1: IF request under reset, then first fetch after release.
    step(1'b0, 1'b1, 7'd5, 1'b0, 1'b0, 7'd0, '0);
    chk("t1_rst_ram_addr", bus.ram_addr, 7'd5);
    step(1'b1, 1'b1, 7'd5, 1'b0, 1'b0, 7'd0, '0);
    step(1'b1, 1'b0, 7'd0, 1'b0, 1'b0, 7'd0, '0);
    chk("t1_if_rdata", bus.if_rdata, 32'hDEADBEEF);

    // Scenario 2: MEM write beats IF, then MEM reads it back.
    step(1'b1, 1'b1, 7'd7, 1'b1, 1'b1, 7'd9, 32'h1234);
    chk("t2_if_stall", bus.if_stall, 1'b1);
    step(1'b1, 1'b1, 7'd7, 1'b1, 1'b0, 7'd9, '0);
    step(1'b1, 1'b0, 7'd0, 1'b0, 1'b0, 7'd0, '0);
    chk("t2_mem_rdata", bus.mem_rdata, 32'h1234);

    // Scenario 3: continuous contention gives M,M,M,I.
    step(1'b1, 1'b0, 7'd0, 1'b0, 1'b0, 7'd0, '0);
    for (int k = 0; k < 12; k++) begin
      step(1'b1, 1'b1, 7'd20, 1'b1, 1'b0, 7'd21, '0);
      chk("t3_if_stall", bus.if_stall, (k % 4 == 3) ? 1'b0 : 1'b1);
    end

    // Scenario 4: alternating single requests, no stalls.
    step(1'b1, 1'b1, 7'd0, 1'b0, 1'b0, 7'd0, '0);
    step(1'b1, 1'b0, 7'd0, 1'b1, 1'b0, 7'd1, '0);
    step(1'b1, 1'b1, 7'd2, 1'b0, 1'b0, 7'd0, '0);
    step(1'b1, 1'b0, 7'd0, 1'b0, 1'b0, 7'd0, '0);

    // Scenario 5: reset right after an IF grant drops its return and the starve count.
    step(1'b1, 1'b1, 7'd3, 1'b0, 1'b0, 7'd0, '0);
    step(1'b0, 1'b0, 7'd0, 1'b0, 1'b0, 7'd0, '0);
    step(1'b0, 1'b0, 7'd0, 1'b0, 1'b0, 7'd0, '0);
    step(1'b1, 1'b0, 7'd0, 1'b0, 1'b0, 7'd0, '0);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b1, 7'd30, 1'b1, 1'b0, 7'd31, '0);
      chk("t5_if_stall", bus.if_stall, (k == 3) ? 1'b0 : 1'b1);
    end

    // Scenario 6: idle.
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 7'd0, 1'b0, 1'b0, 7'd0, '0);

    // Random traffic; stalled requesters hold their request.
    c_ir = 0; c_mr = 0; c_mw = 0; c_ia = '0; c_ma = '0; c_md = '0;
    m_if_stall = 0; m_mem_stall = 0;
    for (int k = 0; k < 400; k++) begin
      c_rst = ($urandom_range(0, 49) != 0);
      if (!m_if_stall) begin
        c_ir = ($urandom_range(0, 2) != 0);
        c_ia = ($urandom_range(0, 7) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 15));
      end
      if (!m_mem_stall) begin
        c_mr = ($urandom_range(0, 1) != 0);
        c_mw = ($urandom_range(0, 2) == 0);
        c_ma = ($urandom_range(0, 7) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 15));
        c_md = $urandom;
      end
      step(c_rst, c_ir, c_ia, c_mr, c_mw, c_ma, c_md);
    end
    step(1'b1, 1'b0, 7'd0, 1'b0, 1'b0, 7'd0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
